// File: rtl/cpu_dump_ctrl_if.sv
// Dump record handshake bus: one register or memory record per transfer.
// A record moves when out_valid and out_ready are both high on a rising edge.
interface cpu_dump_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [15:0] out_addr;
    logic [15:0] out_data;

    modport master (
        output out_valid,
        output out_kind,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_kind,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/cpu_dump_ctrl.sv
// CPU state dump controller.
// On the halt instruction the CPU is frozen, then all 16 registers and data
// memory words 0..MEM_DEPTH-1 are streamed out as records on the dump bus.
// Optional macro DUMP_SKIP_ZERO_EN: memory words reading zero emit no record.
module cpu_dump_ctrl #(
    parameter logic [15:0] HALT_OPCODE = 16'hE000,
    parameter int unsigned MEM_DEPTH   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           instr,
    output logic                  freeze,
    output logic [3:0]            reg_rd_addr,
    input  logic [15:0]           reg_rd_data,
    output logic                  mem_rd_en,
    output logic [15:0]           mem_rd_addr,
    input  logic [15:0]           mem_rd_data,
    cpu_dump_ctrl_if.master       dump,
    output logic                  done,
    output logic [16:0]           rec_count
);

    localparam logic [15:0] LAST_ADDR = 16'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG_LOAD,
        S_REG_SEND,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_MEM_SEND,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_index;
    logic [15:0] r_addr;
    logic        r_freeze;
    logic [3:0]  r_reg_rd_addr;
    logic        r_mem_rd_en;
    logic        r_out_valid;
    logic        r_out_kind;
    logic [15:0] r_out_addr;
    logic [15:0] r_out_data;
    logic        r_done;
    logic [16:0] r_rec_count;
    logic        w_emit;
    logic        w_last;

    // Decide whether the word returned from memory produces a record.
`ifdef DUMP_SKIP_ZERO_EN
    assign w_emit = (mem_rd_data != '0);
`else
    assign w_emit = 1'b1;
`endif

    assign w_last = (r_addr == LAST_ADDR);

    assign freeze         = r_freeze;
    assign reg_rd_addr    = r_reg_rd_addr;
    assign mem_rd_en      = r_mem_rd_en;
    assign mem_rd_addr    = r_addr;
    assign dump.out_valid = r_out_valid;
    assign dump.out_kind  = r_out_kind;
    assign dump.out_addr  = r_out_addr;
    assign dump.out_data  = r_out_data;
    assign done           = r_done;
    assign rec_count      = r_rec_count;

    // Dump sequencer; every output is registered and set up on the transition
    // into the state that owns it, so reg_rd_addr/mem_rd_en are only non-zero
    // while sitting in REG_LOAD/MEM_REQ respectively.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_addr        <= '0;
            r_freeze      <= 1'b0;
            r_reg_rd_addr <= '0;
            r_mem_rd_en   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_kind    <= 1'b0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_done        <= 1'b0;
            r_rec_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr == HALT_OPCODE) begin
                        r_state       <= S_REG_LOAD;
                        r_index       <= '0;
                        r_reg_rd_addr <= '0;
                        r_freeze      <= 1'b1;
                    end
                end
                S_REG_LOAD: begin
                    r_out_kind    <= 1'b0;
                    r_out_addr    <= {12'h000, r_index};
                    r_out_data    <= reg_rd_data;
                    r_out_valid   <= 1'b1;
                    r_reg_rd_addr <= '0;
                    r_state       <= S_REG_SEND;
                end
                S_REG_SEND: begin
                    if (dump.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rec_count <= r_rec_count + 17'd1;
                        if (r_index == 4'd15) begin
                            r_addr      <= '0;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_MEM_REQ;
                        end else begin
                            r_index       <= r_index + 4'd1;
                            r_reg_rd_addr <= r_index + 4'd1;
                            r_state       <= S_REG_LOAD;
                        end
                    end
                end
                S_MEM_REQ: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (w_emit) begin
                        r_out_kind  <= 1'b1;
                        r_out_addr  <= r_addr;
                        r_out_data  <= mem_rd_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_MEM_SEND;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr      <= r_addr + 16'd1;
                        r_mem_rd_en <= 1'b1;
                        r_state     <= S_MEM_REQ;
                    end
                end
                S_MEM_SEND: begin
                    if (dump.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rec_count <= r_rec_count + 17'd1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr      <= r_addr + 16'd1;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_MEM_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_dump_ctrl.md
CPU_DUMP_CTRL -- requirements
Module: cpu_dump_ctrl

Interface
REQ-001 Parameter HALT_OPCODE, default 16'hE000, instruction word that triggers the dump.
REQ-002 Parameter MEM_DEPTH, default 1024, number of data-memory words scanned (addresses 0..MEM_DEPTH-1).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  16  instruction currently decoded by the CPU.
REQ-006 freeze  output  1  stalls the CPU pipeline and write-backs while high.
REQ-007 reg_rd_addr  output  4  register-file debug read address; combinational read data returns same cycle.
REQ-008 reg_rd_data  input  16  register-file debug read data.
REQ-009 mem_rd_en  output  1  data-memory debug read strobe.
REQ-010 mem_rd_addr  output  16  data-memory debug read address.
REQ-011 mem_rd_data  input  16  data-memory read data, valid exactly one cycle after mem_rd_en.
REQ-012 out_valid  output  1  dump record available.
REQ-013 out_ready  input  1  consumer accepts record when high together with out_valid.
REQ-014 out_kind  output  1  0 = register record, 1 = memory record.
REQ-015 out_addr  output  16  register index (zero-extended) or memory address.
REQ-016 out_data  output  16  register or memory content.
REQ-017 done  output  1  dump complete; sticky until reset.
REQ-018 rec_count  output  17  number of records accepted by the consumer.

Function
REQ-019 States SHALL be IDLE, REG_LOAD, REG_SEND, MEM_REQ, MEM_WAIT, MEM_SEND, DONE.
REQ-020 IDLE: freeze=0; when instr==HALT_OPCODE, go to REG_LOAD with reg index 0; freeze=1 from the next cycle in every non-IDLE state.
REQ-021 REG_LOAD: reg_rd_addr=index; latch {0, index, reg_rd_data} into out_kind/out_addr/out_data; set out_valid; go to REG_SEND.
REQ-022 REG_SEND: hold until out_valid&&out_ready; then clear out_valid, increment rec_count; index 15 -> MEM_REQ with address 0, else index+1 -> REG_LOAD.
REQ-023 All 16 registers (0..15) SHALL always be emitted, including zero values.
REQ-024 MEM_REQ: mem_rd_en=1 for one cycle, mem_rd_addr=address; go to MEM_WAIT.
REQ-025 MEM_WAIT: sample mem_rd_data; if emitted, latch {1, address, mem_rd_data}, set out_valid, go to MEM_SEND; if skipped, go to DONE when address==MEM_DEPTH-1, else address+1 -> MEM_REQ.
REQ-026 MEM_SEND: on handshake clear out_valid, increment rec_count; address==MEM_DEPTH-1 -> DONE, else address+1 -> MEM_REQ.
REQ-027 DONE: done=1, freeze=1, out_valid=0, no further reads; exit only by reset.
REQ-028 out_kind/out_addr/out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 out_ready while out_valid=0 SHALL have no effect.
REQ-030 instr==HALT_OPCODE outside IDLE SHALL be ignored (no restart).
REQ-031 mem_rd_en SHALL be 0 outside MEM_REQ; reg_rd_addr SHALL be 0 outside REG_LOAD.
REQ-032 rec_count SHALL not wrap (max 16+MEM_DEPTH records fits 17 bits for MEM_DEPTH<=65536).

Reset
REQ-033 reset SHALL, on the clock edge it is sampled, force IDLE, index=0, address=0, and all outputs to 0 (freeze, out_valid, done, mem_rd_en, rec_count, out_kind, out_addr, out_data).
REQ-034 reset mid-dump SHALL abort immediately; a pending record is dropped, not completed.

Configuration
REQ-035 Macro DUMP_SKIP_ZERO_EN defined: memory words reading 16'd0 SHALL be skipped in MEM_WAIT (no record, no rec_count change).
REQ-036 Macro DUMP_SKIP_ZERO_EN undefined: every memory word SHALL be emitted; total records = 16+MEM_DEPTH.

Verification
REQ-037 Regs r0..r15=i*3, MEM_DEPTH=1024 memory all zero, SKIP_ZERO on, out_ready=1, instr=16'hE000 -> 16 records kind 0 data 0,3,..,45, then done=1, rec_count=16.
REQ-038 SKIP_ZERO on, mem[5]=7, mem[1023]=16'hFFFF -> records after registers: (1,5,7),(1,1023,FFFF) only; rec_count=18.
REQ-039 SKIP_ZERO off, MEM_DEPTH=8 -> 24 records, memory addresses 0..7 in order, done after address 7 handshake.
REQ-040 out_ready held low 10 cycles on register record 4 -> out_valid stays 1, out_addr=4 and out_data unchanged, no mem_rd_en pulses, then single acceptance.
REQ-041 reset asserted while in MEM_SEND at address 3 -> next cycle freeze=0, out_valid=0, rec_count=0, state IDLE; new 16'hE000 restarts at register 0.
REQ-042 instr=16'hE001 or 16'h6000 in IDLE -> freeze stays 0, no records; 16'hE000 repeated during dump -> single pass only.
